// File: rtl/regbank_dump_ctrl.sv
// Purpose : halted-pipeline debug dump; reads every bank register via read port A
//           and streams each word out as bytes, LSB first, over valid/ready.
// Ports   : i_start/i_halted control; o_addr_ra/i_data_ra to bank port A
//           (1-cycle registered read); o_byte/o_valid/i_ready byte stream;
//           o_index, o_busy status; o_done / o_abort one-cycle completion pulses.
module regbank_dump_ctrl #(
    parameter int NB_REG     = 5,
    parameter int NB_DATA    = 32,
    parameter int N_REGISTER = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_halted,
    output logic [NB_REG-1:0]  o_addr_ra,
    input  logic [NB_DATA-1:0] i_data_ra,
    output logic [7:0]         o_byte,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_REG-1:0]  o_index,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_abort
);

    localparam int NB_BYTES = NB_DATA / 8;
    localparam int NB_BCNT  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
    localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(NB_BYTES - 1);
    localparam logic [NB_REG-1:0]  LAST_REG  = NB_REG'(N_REGISTER - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_CAPTURE,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t              state_q;
    logic [NB_REG-1:0]   index_q;
    logic [NB_BCNT-1:0]  bcnt_q;
    logic [NB_DATA-1:0]  word_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;
    logic                abort_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            index_q <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            // completion pulses last exactly one cycle
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (i_start && i_halted) begin
                    state_q <= ST_ADDR;
                    index_q <= '0;
                    bcnt_q  <= '0;
                    busy_q  <= 1'b1;
                end
            end else if (!i_halted) begin
                // abort wins over any handshake in the same cycle; pending byte is dropped
                state_q <= ST_IDLE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                abort_q <= 1'b1;
            end else begin
                case (state_q)
                    // bank registers index_q at the edge leaving ADDR
                    ST_ADDR: state_q <= ST_CAPTURE;
                    // bank read data is valid during CAPTURE
                    ST_CAPTURE: begin
                        word_q  <= i_data_ra;
                        valid_q <= 1'b1;
                        state_q <= ST_SEND;
                    end
                    ST_SEND: begin
                        if (valid_q && i_ready) begin
                            word_q <= word_q >> 8;
                            if (bcnt_q == LAST_BYTE) begin
                                bcnt_q  <= '0;
                                valid_q <= 1'b0;
                                if (index_q == LAST_REG) begin
                                    state_q <= ST_DONE;
                                    done_q  <= 1'b1;
                                end else begin
                                    index_q <= index_q + 1'b1;
                                    state_q <= ST_ADDR;
                                end
                            end else begin
                                bcnt_q <= bcnt_q + 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // the bank address and the reported index are the same register in every state
    assign o_addr_ra = index_q;
    assign o_index   = index_q;
    assign o_byte    = word_q[7:0];
    assign o_valid   = valid_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_abort   = abort_q;

endmodule

// File: doc/regbank_dump_ctrl.md
# regbank_dump_ctrl

Debug-side sequencer that reads every register of the decode-stage bank register file through read port A while the pipeline is halted. It streams the contents out as bytes over a valid/ready handshake toward the debug unit / UART transmitter. The block owns the read-A address mux input during a dump, matches the bank's one-cycle registered read latency, serializes each word LSB-first, and reports completion or abort.

## Interface
- NB_REG, 5, register address width
- NB_DATA, 32, register data width; must be a multiple of 8
- N_REGISTER, 32, number of registers dumped (addresses 0..N_REGISTER-1); N_REGISTER <= 2**NB_REG
- i_clock  in  1  clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  dump request; sampled only in IDLE
- i_halted  in  1  pipeline halted; dump proceeds only while high
- o_addr_ra  out  NB_REG  read address to bank port A (selected by debug mux while o_busy)
- i_data_ra  in  NB_DATA  bank port A read data (registered in bank, 1-cycle latency)
- o_byte  out  8  current output byte
- o_valid  out  1  o_byte valid
- i_ready  in  1  consumer accepts o_byte when o_valid & i_ready at a rising edge
- o_index  out  NB_REG  register number currently being sent
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse: full dump completed
- o_abort  out  1  one-cycle pulse: dump aborted because i_halted fell

## Operation
- Reset: state IDLE; o_addr_ra, o_byte, o_index = 0; o_valid, o_busy, o_done, o_abort = 0; shift register and byte counter cleared.
- States: IDLE, ADDR, CAPTURE, SEND, DONE.
- IDLE: i_start & i_halted -> ADDR, index <= 0, byte count <= 0. i_start with i_halted low is ignored (no pulse).
- ADDR: o_addr_ra = index (it equals index in every state). Bank samples address at the edge ending ADDR -> CAPTURE.
- CAPTURE: i_data_ra is valid; latch into word shift register at the edge ending CAPTURE -> SEND.
- SEND: o_valid = 1, o_byte = word[7:0]. On o_valid & i_ready: shift word right by 8, byte count + 1. After the handshake on byte NB_DATA/8-1: if index == N_REGISTER-1 -> DONE, else index + 1 and -> ADDR.
- DONE: o_done = 1 for exactly this cycle -> IDLE.
- Abort: i_halted low in ADDR, CAPTURE, SEND or DONE -> IDLE at the next edge. o_abort is high for one cycle, the cycle after i_halted was sampled low. o_valid drops immediately with the state change, and any pending byte is discarded. Abort takes priority over handshake completion in the same cycle. o_done is not pulsed on abort.
- o_byte and o_valid are driven from registered state/shift register. They stay stable while o_valid & !i_ready.
- i_ready with o_valid low has no effect. i_start outside IDLE is ignored.
- o_index = index register. It resets to 0 and holds its last value after DONE/abort until the next start.
- No writes are issued to the bank. Bank write-port activity during a dump is outside this block's guarantee.

## Timing
- Start accepted at edge E0 (IDLE, i_start & i_halted): ADDR in cycle E0..E1, CAPTURE E1..E2, first o_valid high from E2.
- Per register with i_ready held high: 2 overhead cycles + NB_DATA/8 byte cycles (6 at defaults).
- Full dump at defaults with i_ready high: 32*6 = 192 cycles, then 1 DONE cycle. o_done is high in cycle 193 after E0. o_busy is high for 193 cycles.
- Back-pressure: each low cycle of i_ready in SEND adds exactly one cycle.
- i_reset overrides everything in any state, including mid-dump.

## Test plan
- Bank preloaded registers[i] = 0xA0B0C000 + i, i_halted = 1, i_ready = 1, pulse i_start -> bytes 00 C0 B0 A0, 01 C0 B0 A0, ... 1F C0 B0 A0 (128 bytes). o_valid first high 2 cycles after start. o_done pulses once at cycle 193. o_busy is low afterwards.
- Same setup with i_ready toggling 1,0,1,0 -> identical byte stream. o_byte stable during every low-ready cycle with o_valid high. Total length is 193 + number of low-ready cycles in SEND.
- i_start pulsed with i_halted = 0 -> stays IDLE, o_busy = 0, no o_valid/o_done/o_abort.
- Drop i_halted during the 3rd byte of register 5 -> next cycle IDLE, o_abort single pulse, o_valid = 0, no o_done, o_index = 5. A new start restarts from register 0.
- Assert i_reset for 1 cycle mid-SEND -> all outputs return to reset values next cycle. A subsequent start dumps all 32 registers correctly.
- i_start held high through the whole dump and for 1 cycle after o_done -> a second dump starts from IDLE. No restart occurs during the first dump.
